// File: rtl/operand_select_pipe.sv
// operand_select_pipe: selects one of NUM_SRC packed operands per input beat
// and buffers it in a two-entry pipe (output register plus one skid register).
// in_ready is registered-only: it depends solely on skid occupancy.
// Optional feature macro: OPSEL_RANGE_CHK_EN adds a sticky sel_err output
// flagging any accepted beat whose sel is outside 0..NUM_SRC-1.
//
// Handshake: a beat transfers on any rising edge where valid && ready are both
// high; the producer holds its data stable until that edge, and ready never
// depends combinationally on the same interface's valid.
module operand_select_pipe #(
   parameter int WIDTH   = 8,
   parameter int NUM_SRC = 4,
   parameter int SEL_W   = 2
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [NUM_SRC*WIDTH-1:0] src,
   input  logic [SEL_W-1:0]         sel,
   input  logic                     in_valid,
   output logic                     in_ready,
   output logic [WIDTH-1:0]         B,
   output logic                     out_valid,
   input  logic                     out_ready,
`ifdef OPSEL_RANGE_CHK_EN
   output logic                     sel_err,
`endif
   output logic [1:0]               level
);

   logic [WIDTH-1:0] sel_val;
   logic [WIDTH-1:0] skid;
   logic             skid_valid;
   logic             accept;
   logic             consume;
   logic             sel_oor;

   // Operand mux; out-of-range selects produce an all-zero operand.
   always_comb begin
      sel_val = '0;
      for (int k = 0; k < NUM_SRC; k++) begin
         if (32'(sel) == 32'(k)) sel_val = src[k*WIDTH +: WIDTH];
      end
   end

   assign sel_oor  = (32'(sel) >= 32'(NUM_SRC));
   assign in_ready = !skid_valid;
   assign accept   = in_valid && in_ready;
   assign consume  = out_valid && out_ready;
   assign level    = 2'(out_valid) + 2'(skid_valid);

   // Output/skid register updates; skid only fills when the output stalls.
   always_ff @(posedge clk) begin
      if (reset) begin
         out_valid  <= 1'b0;
         skid_valid <= 1'b0;
         B          <= '0;
         skid       <= '0;
      end else if (consume) begin
         if (skid_valid) begin
            // in_ready is low here, so no new beat competes with the skid.
            B          <= skid;
            skid_valid <= 1'b0;
         end else if (accept) begin
            B <= sel_val;
         end else begin
            out_valid <= 1'b0;
         end
      end else if (accept) begin
         if (!out_valid) begin
            B         <= sel_val;
            out_valid <= 1'b1;
         end else begin
            skid       <= sel_val;
            skid_valid <= 1'b1;
         end
      end
   end

`ifdef OPSEL_RANGE_CHK_EN
   // Sticky flag for accepted out-of-range selects; only reset clears it.
   always_ff @(posedge clk) begin
      if (reset)                  sel_err <= 1'b0;
      else if (accept && sel_oor) sel_err <= 1'b1;
   end
`else
   logic unused_sel_oor;
   assign unused_sel_oor = sel_oor;
`endif

endmodule
